prover_compute_h_seq: RTL
=========================

Name: prover_compute_h_seq

Overview:
- Sequencer and accumulator that sits directly downstream of the compute_h input mux. It also drives that mux's select.
- It steps the select count through all nInputs mux sources.
- For each source it issues the muxed value and a coefficient to an external field multiplier, using a request/done handshake.
- It sums the products mod `F_Q into one field element h.
- It is the control and reduction stage for one compute_h evaluation in the prover pipeline.

Parameters:
- nInputs, 2, number of mux sources to step through; must be >= 2, otherwise elaboration fails with a named error module.
- nInBits, $clog2(nInputs), width of the select count; must not be overridden, otherwise elaboration fails with a named error module.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  start pulse; honoured only while ready_out=1.
- count_out  output  nInBits  select for the upstream mux.
- mux_val_in  input  `F_NBITS  muxed value for the current count_out.
- coeff_in  input  `F_NBITS  coefficient for the current count_out.
- mul_en_out  output  1  one-cycle multiply request.
- mul_a_out  output  `F_NBITS  multiplier operand A, latched.
- mul_b_out  output  `F_NBITS  multiplier operand B, latched.
- mul_ready_in  input  1  one-cycle pulse; the product is valid on this cycle.
- mul_result_in  input  `F_NBITS  product, already reduced below `F_Q.
- h_out  output  `F_NBITS  accumulated result; holds its value until the next start.
- ready_out  output  1  high when idle and h_out is valid.

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, count_out=0, accumulator=0, h_out=0.
  - mul_en_out=0, mul_a_out=0, mul_b_out=0.
  - ready_out=1.
- ready_out is 1 exactly when state=IDLE.
- States and transitions:
  - IDLE: on en=1, clear the accumulator to 0, set count_out=0 and go to ISSUE. If en=0, hold.
  - ISSUE (one cycle): sample mux_val_in into mul_a_out and coeff_in into mul_b_out. Assert mul_en_out for exactly this one cycle (registered, so visible in the following cycle). Go to WAIT.
  - WAIT: hold mul_a_out, mul_b_out and count_out stable. On mul_ready_in=1, latch mul_result_in and go to ADD.
  - ADD (one cycle):
    - Compute s = acc + prod using an `F_NBITS+1-bit sum. If s >= `F_Q then acc <= s - `F_Q, else acc <= s.
    - If count_out == nInputs-1: h_out <= the new acc, count_out <= 0, go to IDLE.
    - Otherwise: count_out <= count_out+1, go to ISSUE.
- count_out changes only in the IDLE->ISSUE and ADD transitions. The upstream mux is combinational, so mux_val_in and coeff_in are valid in ISSUE.
- Latency: with multiplier latency L cycles (mul_ready_in arrives L>=1 cycles after mul_en_out is visible), a full run takes nInputs*(L+3)+1 cycles from en to ready_out rising.
- Boundaries:
  - en while busy: ignored; no restart and no queueing.
  - mul_ready_in outside WAIT: ignored, including a pulse coincident with mul_en_out.
  - en together with rst: rst wins.
  - Reset mid-operation: immediate return to the reset values. A multiplier response that arrives after reset is ignored.
  - Summing wraps mod `F_Q only; the accumulator never holds a value >= `F_Q.
  - h_out is unchanged during a run. It updates only in the final ADD.

Test Plan:
- Basic sum: nInputs=4, vals 1,2,3,4, coeff 5, model multiplier L=1 -> h_out=50; ready_out rises 4*4+1=17 cycles after en; count_out sequence 0,1,2,3,0.
- Modular wrap: nInputs=2, products `F_Q-1 and 2 -> h_out=1. Products `F_Q-1 and `F_Q-1 -> h_out=`F_Q-2.
- Variable latency: multiplier latency 1, 7 and 3 on successive steps.
  - mul_a_out and mul_b_out are stable throughout each WAIT.
  - mul_en_out is high exactly one cycle per step.
  - Result matches the model.
- Protocol abuse: en pulsed mid-run, and a spurious mul_ready_in during ISSUE and IDLE -> no restart, result unchanged, exactly nInputs requests issued.
- Reset mid-run: assert rst in WAIT of step 2, then send a late mul_ready_in -> all outputs return to the reset values, the late response is ignored, and the next run gives the correct h_out.
- Back-to-back runs: en in the first cycle ready_out=1 after a completion -> the accumulator clears, the second h_out reflects only the second run, and h_out holds the first result until the final ADD.

Source files
------------

// File: rtl/prover_compute_h_seq.sv
// compute_h sequencer: steps the mux select, issues one multiply per source, sums the products mod F_Q into h_out.
// A run takes nInputs*(L+3)+1 cycles; it waits indefinitely on mul_ready_in and ignores en while busy.
`timescale 1ns/1ps
`ifndef F_NBITS
`define F_NBITS 16
`endif
`ifndef F_Q
`define F_Q 65521
`endif

module prover_compute_h_seq #(
  parameter int nInputs = 2,
  parameter int nInBits = $clog2(nInputs)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  output logic [nInBits-1:0]  count_out,
  input  logic [`F_NBITS-1:0] mux_val_in,
  input  logic [`F_NBITS-1:0] coeff_in,
  output logic                mul_en_out,
  output logic [`F_NBITS-1:0] mul_a_out,
  output logic [`F_NBITS-1:0] mul_b_out,
  input  logic                mul_ready_in,
  input  logic [`F_NBITS-1:0] mul_result_in,
  output logic [`F_NBITS-1:0] h_out,
  output logic                ready_out
);

  if (nInputs < 2) begin : g_err_ninputs_too_small
    $fatal(1, "prover_compute_h_seq: nInputs must be >= 2");
  end
  if (nInBits != $clog2(nInputs)) begin : g_err_ninbits_overridden
    $fatal(1, "prover_compute_h_seq: nInBits must equal $clog2(nInputs)");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ADD} state_t;

  localparam logic [nInBits-1:0]  LP_LAST = nInBits'(nInputs - 1);
  localparam logic [`F_NBITS:0]   LP_Q_W  = (`F_NBITS + 1)'(`F_Q);
  localparam logic [`F_NBITS-1:0] LP_Q    = `F_NBITS'(`F_Q);

  state_t              r_state;
  logic [nInBits-1:0]  r_count;
  logic [`F_NBITS-1:0] r_acc;
  logic [`F_NBITS-1:0] r_prod;
  logic [`F_NBITS-1:0] r_a;
  logic [`F_NBITS-1:0] r_b;
  logic [`F_NBITS-1:0] r_h;
  logic                r_mul_en;
  logic                r_ready;

  logic [`F_NBITS:0]   w_sum;
  logic                w_wrap;
  logic [`F_NBITS-1:0] w_acc_next;

  // Both operands are below F_Q, so one conditional subtract fully reduces;
  // the true difference fits in F_NBITS bits, so the low-bit subtract is exact.
  assign w_sum      = {1'b0, r_acc} + {1'b0, r_prod};
  assign w_wrap     = (w_sum >= LP_Q_W);
  assign w_acc_next = w_wrap ? (w_sum[`F_NBITS-1:0] - LP_Q) : w_sum[`F_NBITS-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_acc    <= '0;
      r_prod   <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_h      <= '0;
      r_mul_en <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      r_mul_en <= 1'b0;
      case (r_state)
        IDLE: begin
          if (en) begin
            r_acc   <= '0;
            r_count <= '0;
            r_ready <= 1'b0;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_a      <= mux_val_in;
          r_b      <= coeff_in;
          r_mul_en <= 1'b1;
          r_state  <= WAIT;
        end
        WAIT: begin
          // A response in the same cycle as the visible request is too early to be genuine.
          if (mul_ready_in && !r_mul_en) begin
            r_prod  <= mul_result_in;
            r_state <= ADD;
          end
        end
        ADD: begin
          r_acc <= w_acc_next;
          if (r_count == LP_LAST) begin
            r_h     <= w_acc_next;
            r_count <= '0;
            r_ready <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_count <= r_count + 1'b1;
            r_state <= ISSUE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign count_out  = r_count;
  assign mul_en_out = r_mul_en;
  assign mul_a_out  = r_a;
  assign mul_b_out  = r_b;
  assign h_out      = r_h;
  assign ready_out  = r_ready;

endmodule
